raster_cmd_sched: RTL

RASTER_CMD_SCHED -- requirements
Module: raster_cmd_sched

---
 rtl/raster_cmd_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/raster_cmd_sched.sv
// Raster command scheduler: in-order TRI/CLEAR/STATE/FENCE queue feeding the rasterizer.
// Define RASTER_CMD_SCHED_STATS_EN to build the tri_count/clear_count statistics.
package raster_cmd_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef enum logic [2:0] {
    DF_NEVER, DF_LESS, DF_EQUAL, DF_LEQUAL,
    DF_GREATER, DF_NOTEQUAL, DF_GEQUAL, DF_ALWAYS
  } depth_func_t;

  localparam logic [1:0] OP_TRI   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_STATE = 2'd2;
  localparam logic [1:0] OP_FENCE = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    vertex_t     v0;
    vertex_t     v1;
    vertex_t     v2;
    logic [4:0]  st;
    depth_func_t fn;
    logic [15:0] cv;
  } cmd_t;
endpackage

module raster_cmd_sched
  import raster_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  vertex_t     cmd_v0,
  input  vertex_t     cmd_v1,
  input  vertex_t     cmd_v2,
  input  logic [4:0]  cmd_state,
  input  depth_func_t cmd_depth_func,
  input  logic [15:0] cmd_clear_value,
  output vertex_t     rast_v0,
  output vertex_t     rast_v1,
  output vertex_t     rast_v2,
  output logic        rast_tri_valid,
  input  logic        rast_tri_ready,
  input  logic        rast_busy,
  output logic        depth_clear,
  output logic [15:0] depth_clear_value,
  input  logic        depth_clearing,
  output logic        tex_enable,
  output logic        modulate_enable,
  output logic        tex_filter_bilinear,
  output logic        depth_test_enable,
  output logic        depth_write_enable,
  output depth_func_t depth_func,
  output logic        fence_done,
  output logic        idle,
  output logic [31:0] tri_count,
  output logic [15:0] clear_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRI, S_DRAIN, S_APPLY,
    S_CLEAR_REQ, S_CLEAR_WAIT, S_FENCE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t        mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  cmd_t        in_cmd, head;
  logic        full, empty, push, pop;
  logic        is_clear, is_fence;
  logic [4:0]  cfg_q;
  depth_func_t fn_q;
  logic [15:0] cv_q;

  assign empty = (wr_q == rd_q);
  assign full = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  assign in_cmd = {cmd_op, cmd_v0, cmd_v1, cmd_v2,
                   cmd_state, cmd_depth_func, cmd_clear_value};
  assign head = mem_q[rd_q[AW-1:0]];
  assign is_clear = (head.op == OP_CLEAR);
  assign is_fence = (head.op == OP_FENCE);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts idle cycles in DRAIN and marks the settle cycle in CLEAR_WAIT
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    pop            = 1'b0;
    rast_tri_valid = 1'b0;
    depth_clear    = 1'b0;
    fence_done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = (head.op == OP_TRI) ? S_TRI : S_DRAIN;
      end
      S_TRI: begin
        rast_tri_valid = 1'b1;
        if (rast_tri_ready) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        cnt_d = rast_busy ? '0 : cnt_q + 1'b1;
        if (cnt_d == CW'(DRAIN_CYCLES)) begin
          unique case (1'b1)
            is_clear: state_d = S_CLEAR_REQ;
            is_fence: state_d = S_FENCE;
            default:  state_d = S_APPLY;
          endcase
        end
      end
      S_APPLY: begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR_REQ: begin
        depth_clear = 1'b1;
        state_d     = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        cnt_d = CW'(1);
        if (cnt_q != '0 && !depth_clearing) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FENCE: begin
        fence_done = 1'b1;
        pop        = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      fn_q  <= DF_NEVER;
      cv_q  <= '0;
    end else begin
      if (state_q == S_APPLY) begin
        cfg_q <= head.st;
        fn_q  <= head.fn;
      end
      if (state_q == S_DRAIN && state_d == S_CLEAR_REQ) cv_q <= head.cv;
    end
  end

  assign rast_v0             = head.v0;
  assign rast_v1             = head.v1;
  assign rast_v2             = head.v2;
  assign tex_enable          = cfg_q[0];
  assign modulate_enable     = cfg_q[1];
  assign tex_filter_bilinear = cfg_q[2];
  assign depth_test_enable   = cfg_q[3];
  assign depth_write_enable  = cfg_q[4];
  assign depth_func          = fn_q;
  assign depth_clear_value   = cv_q;
  assign idle                = empty && (state_q == S_IDLE);

`ifdef RASTER_CMD_SCHED_STATS_EN
  logic [31:0] tri_cnt_q;
  logic [15:0] clr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_cnt_q <= '0;
      clr_cnt_q <= '0;
    end else begin
      if (state_q == S_TRI && rast_tri_ready) tri_cnt_q <= tri_cnt_q + 32'd1;
      if (state_q == S_CLEAR_WAIT && pop) clr_cnt_q <= clr_cnt_q + 16'd1;
    end
  end

  assign tri_count   = tri_cnt_q;
  assign clear_count = clr_cnt_q;
`else
  assign tri_count   = '0;
  assign clear_count = '0;
`endif
endmodule
